// File: rtl/delay_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : delay_arbiter
//  Purpose  : Round-robin arbiter for one shared tick-driven countdown timer.
//             Each of four requesters is granted in turn. It receives a
//             one-cycle done strobe after its programmed number of tick
//             rising edges.
//  Revision : 1.0 - initial release
// ============================================================================
module delay_arbiter #(
    parameter int W = 8
) (
    input  logic           clock,
    input  logic           Clear_b,
    input  logic           tick,
    input  logic [3:0]     req,
    input  logic [4*W-1:0] delay,
    output logic [3:0]     grant,
    output logic [3:0]     done,
    output logic           busy,
    output logic [W-1:0]   remaining
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t         r_state,     w_state_nxt;
    logic [3:0]     r_grant,     w_grant_nxt;
    logic [3:0]     r_done,      w_done_nxt;
    logic           r_busy,      w_busy_nxt;
    logic [W-1:0]   r_remaining, w_remaining_nxt;
    logic [1:0]     r_ptr,       w_ptr_nxt;
    logic [1:0]     r_owner,     w_owner_nxt;
    logic           r_tick_prev;

    logic           w_tick_ev;
    logic           w_pick_valid;
    logic [1:0]     w_pick_idx;
    logic [W-1:0]   w_delay_arr [4];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_delay_fields
            assign w_delay_arr[gi] = delay[gi*W +: W];
        end
    endgenerate

    assign w_tick_ev = tick & ~r_tick_prev;

    // Scan from the lowest priority (ptr) up to ptr+1, so the highest-priority
    // requester in the search order is the last one written.
    always_comb begin
        logic [1:0] w_cand;
        w_pick_valid = 1'b0;
        w_pick_idx   = r_ptr;
        w_cand       = r_ptr;
        for (int k = 4; k >= 1; k--) begin
            w_cand = r_ptr + 2'(k);
            if (req[w_cand]) begin
                w_pick_valid = 1'b1;
                w_pick_idx   = w_cand;
            end
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_grant_nxt     = r_grant;
        w_done_nxt      = '0;
        w_remaining_nxt = r_remaining;
        w_ptr_nxt       = r_ptr;
        w_owner_nxt     = r_owner;
        case (r_state)
            S_IDLE: begin
                w_grant_nxt     = '0;
                w_remaining_nxt = '0;
                if (w_pick_valid) begin
                    w_grant_nxt     = 4'b0001 << w_pick_idx;
                    w_owner_nxt     = w_pick_idx;
                    w_remaining_nxt = w_delay_arr[w_pick_idx];
                    if (w_delay_arr[w_pick_idx] == '0) begin
                        w_state_nxt = S_DONE;
                        w_done_nxt  = 4'b0001 << w_pick_idx;
                    end else begin
                        w_state_nxt = S_COUNT;
                    end
                end
            end
            S_COUNT: begin
                // Abort wins over a final tick landing in the same cycle.
                if (!req[r_owner]) begin
                    w_state_nxt     = S_IDLE;
                    w_grant_nxt     = '0;
                    w_remaining_nxt = '0;
                    w_ptr_nxt       = r_owner;
                end else if (w_tick_ev) begin
                    if (r_remaining > W'(1)) begin
                        w_remaining_nxt = r_remaining - W'(1);
                    end else begin
                        w_remaining_nxt = '0;
                        w_done_nxt      = r_grant;
                        w_state_nxt     = S_DONE;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt     = S_IDLE;
                w_grant_nxt     = '0;
                w_remaining_nxt = '0;
                w_ptr_nxt       = r_owner;
            end
            default: begin
                w_state_nxt     = S_IDLE;
                w_grant_nxt     = '0;
                w_remaining_nxt = '0;
            end
        endcase
        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    always_ff @(posedge clock or negedge Clear_b) begin
        if (!Clear_b) begin
            r_state     <= S_IDLE;
            r_grant     <= '0;
            r_done      <= '0;
            r_busy      <= 1'b0;
            r_remaining <= '0;
            r_ptr       <= 2'd3;
            r_owner     <= 2'd0;
            r_tick_prev <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_grant     <= w_grant_nxt;
            r_done      <= w_done_nxt;
            r_busy      <= w_busy_nxt;
            r_remaining <= w_remaining_nxt;
            r_ptr       <= w_ptr_nxt;
            r_owner     <= w_owner_nxt;
            r_tick_prev <= tick;
        end
    end

    assign grant     = r_grant;
    assign done      = r_done;
    assign busy      = r_busy;
    assign remaining = r_remaining;

endmodule
`default_nettype wire

// File: tb/tb_delay_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_delay_arbiter
//  Purpose  : Directed and randomized self-checking bench for delay_arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_delay_arbiter;

    localparam int W = 8;

    logic           clock = 1'b0;
    logic           Clear_b;
    logic           tick;
    logic [3:0]     req;
    logic [4*W-1:0] delay;
    logic [3:0]     grant;
    logic [3:0]     done;
    logic           busy;
    logic [W-1:0]   remaining;

    int n_checks = 0;
    int n_fail   = 0;

    delay_arbiter #(.W(W)) dut (
        .clock     (clock),
        .Clear_b   (Clear_b),
        .tick      (tick),
        .req       (req),
        .delay     (delay),
        .grant     (grant),
        .done      (done),
        .busy      (busy),
        .remaining (remaining)
    );

    always #5 clock = ~clock;

    // Transaction-level view: who owns the timer, how many ticks remain,
    // whether the owner is in its completion cycle, and the fairness pointer.
    typedef struct packed {
        bit has;
        int owner;
        bit dn;
        int rem;
        int ptr;
        bit tprev;
    } mst_t;

    mst_t m = '{has: 1'b0, owner: 0, dn: 1'b0, rem: 0, ptr: 3, tprev: 1'b0};

    function automatic mst_t model_next(mst_t s, logic [3:0] r, logic t, logic [4*W-1:0] d);
        mst_t n;
        bit   ev;
        n       = s;
        ev      = t && !s.tprev;
        n.tprev = t;
        if (!s.has) begin
            n.rem = 0;
            for (int k = 1; k <= 4; k++) begin
                int idx;
                idx = (s.ptr + k) % 4;
                if (r[idx] && !n.has) begin
                    n.has   = 1'b1;
                    n.owner = idx;
                    n.rem   = int'(d[idx*W +: W]);
                    n.dn    = (n.rem == 0);
                end
            end
        end else if (s.dn) begin
            n.has = 1'b0;
            n.dn  = 1'b0;
            n.ptr = s.owner;
            n.rem = 0;
        end else if (!r[s.owner]) begin
            n.has = 1'b0;
            n.ptr = s.owner;
            n.rem = 0;
        end else if (ev) begin
            if (s.rem <= 1) begin
                n.rem = 0;
                n.dn  = 1'b1;
            end else begin
                n.rem = s.rem - 1;
            end
        end
        return n;
    endfunction

    always @(posedge clock or negedge Clear_b) begin
        if (!Clear_b)
            m <= '{has: 1'b0, owner: 0, dn: 1'b0, rem: 0, ptr: 3, tprev: 1'b0};
        else
            m <= model_next(m, req, tick, delay);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    always @(negedge clock) begin
        logic [3:0] exp_g;
        exp_g = m.has ? (4'b0001 << m.owner) : 4'b0000;
        chk("model_grant", 32'(grant), 32'(exp_g));
        chk("model_done", 32'(done), m.dn ? 32'(exp_g) : 32'd0);
        chk("model_busy", 32'(busy), 32'(m.has));
        chk("model_remaining", 32'(remaining), m.rem);
    end

    task automatic cyc();
        @(posedge clock);
        #2;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    logic [3:0] exp31 [3] = '{4'b0001, 4'b0100, 4'b0001};

    initial begin
        int         got;
        logic [3:0] prevg;
        Clear_b = 1'b0;
        tick    = 1'b0;
        req     = '0;
        delay   = '0;
        repeat (3) @(posedge clock);
        #2;
        chk("reset_grant", 32'(grant), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_remaining", 32'(remaining), 32'd0);
        Clear_b = 1'b1;

        // Basic countdown of 3 ticks on requester 0
        delay = {8'd0, 8'd0, 8'd0, 8'd3};
        req   = 4'b0001;
        cyc();
        chk("r29_grant", 32'(grant), 32'd1);
        chk("r29_remaining", 32'(remaining), 32'd3);
        chk("r29_busy", 32'(busy), 32'd1);
        for (int p = 0; p < 3; p++) begin
            tick = 1'b1;
            cyc();
            tick = 1'b0;
            chk("r29_remaining_dec", 32'(remaining), 32'(2 - p));
            chk("r29_done", 32'(done), (p == 2) ? 32'd1 : 32'd0);
            cyc();
        end
        chk("r29_grant_off", 32'(grant), 32'd0);
        chk("r29_done_off", 32'(done), 32'd0);
        req = '0;
        cyc();

        // Zero delay completes in the grant cycle
        delay = {8'd9, 8'd0, 8'd9, 8'd9};
        req   = 4'b0100;
        cyc();
        chk("r32_grant", 32'(grant), 32'h4);
        chk("r32_done", 32'(done), 32'h4);
        chk("r32_remaining", 32'(remaining), 32'd0);
        req = '0;
        cyc();
        chk("r32_release", 32'(grant), 32'd0);

        // Level tick counts only once, then owner aborts
        delay = {8'd0, 8'd0, 8'd0, 8'd5};
        req   = 4'b0001;
        cyc();
        chk("r33_start", 32'(remaining), 32'd5);
        tick = 1'b1;
        repeat (10) cyc();
        chk("r33_level_tick", 32'(remaining), 32'd4);
        tick = 1'b0;
        repeat (2) cyc();
        req = '0;
        cyc();
        chk("r34_abort_grant", 32'(grant), 32'd0);
        chk("r34_abort_busy", 32'(busy), 32'd0);
        chk("r34_abort_done", 32'(done), 32'd0);

        // Asynchronous clear during a countdown
        delay = {8'd1, 8'd1, 8'd5, 8'd1};
        req   = 4'b0010;
        cyc();
        chk("r34_grant1", 32'(grant), 32'h2);
        Clear_b = 1'b0;
        #1;
        chk("r34_async_grant", 32'(grant), 32'd0);
        chk("r34_async_busy", 32'(busy), 32'd0);
        cyc();
        Clear_b = 1'b1;
        delay   = {4{8'd1}};
        req     = 4'b1111;
        cyc();
        chk("r34_after_reset", 32'(grant), 32'd1);

        // Everyone requesting, each leaves after service
        for (int i = 0; i < 4; i++) begin
            chk("r30_grant", 32'(grant), 32'd1 << i);
            tick = 1'b1;
            cyc();
            tick = 1'b0;
            chk("r30_done", 32'(done), 32'd1 << i);
            req[i] = 1'b0;
            cyc();
            cyc();
        end
        chk("r30_idle", 32'(grant), 32'd0);

        // Two persistent requesters must alternate
        delay = {4{8'd2}};
        req   = 4'b0101;
        got   = 0;
        prevg = '0;
        for (int c = 0; c < 80 && got < 3; c++) begin
            tick = ~tick;
            cyc();
            if (grant != 4'b0000 && prevg == 4'b0000) begin
                chk("r31_owner", 32'(grant), 32'(exp31[got]));
                got++;
            end
            prevg = grant;
        end
        chk("r31_owner_count", 32'(got), 32'd3);
        req  = '0;
        tick = 1'b0;
        repeat (3) cyc();

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 7) == 0) req[b] = ~req[b];
            for (int b = 0; b < 4; b++)
                delay[b*W +: W] = W'($urandom_range(0, 5));
            tick = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 399) == 0) begin
                Clear_b = 1'b0;
                cyc();
                Clear_b = 1'b1;
            end else begin
                cyc();
            end
        end
        req  = '0;
        tick = 1'b0;
        repeat (4) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
